instr_issuer: RTL and testbench

//  Host-side driver for the cpu load/start/wait handshake.

---
 rtl/cpu_isa_pkg.sv | 31 +++
 rtl/instr_fifo.sv | 45 ++++
 rtl/instr_issuer.sv | 147 ++++++++++++++
 tb/tb_instr_issuer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// SIMPLE RISC encoding constants and the enums shared by the instruction issuer.
package cpu_isa_pkg;

    localparam logic [2:0] OPC_ALU = 3'b101;
    localparam logic [2:0] OPC_MOV = 3'b110;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    // Codes 6 and 7 are deliberately left out: they are the illegal kinds.
    typedef enum logic [2:0] {
        K_MOVI = 3'd0,
        K_MOV  = 3'd1,
        K_ADD  = 3'd2,
        K_CMP  = 3'd3,
        K_AND  = 3'd4,
        K_MVN  = 3'd5
    } req_kind_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_START = 2'd2,
        S_RUN   = 2'd3
    } issue_state_e;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with async reset; wrap-bit pointers give full/empty directly.
// Output is the current head word (show-ahead), valid whenever empty is low.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone decide what is visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/instr_issuer.sv
// Encodes host requests into SIMPLE RISC words, queues them, and drives each through
// the cpu load/start/wait handshake, capturing result and flags or abandoning on timeout.
module instr_issuer
    import cpu_isa_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_kind,
    input  logic [2:0]  req_rn,
    input  logic [2:0]  req_rd,
    input  logic [2:0]  req_rm,
    input  logic [1:0]  req_sh,
    input  logic [7:0]  req_imm8,
    output logic [15:0] cpu_in,
    output logic        cpu_load,
    output logic        cpu_s,
    input  logic        cpu_w,
    input  logic [15:0] cpu_out,
    input  logic        cpu_n,
    input  logic        cpu_v,
    input  logic        cpu_z,
    output logic        res_valid,
    output logic [15:0] res_data,
    output logic [2:0]  res_flags,
    output logic        err_illegal,
    output logic        err_timeout
);
    localparam int             TW    = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT - 1);

    issue_state_e  state;
    logic [TW-1:0] tcnt;
    logic [15:0]   enc_word;
    logic          enc_legal;
    logic          accept;
    logic          push;
    logic          pop;
    logic          busy;
    logic          timeout_hit;
    logic [15:0]   head;
    logic          full;
    logic          empty;

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (req_kind)
            K_MOVI:  enc_word = {OPC_MOV, OP_MOV_IMM, req_rn, req_imm8};
            K_MOV:   enc_word = {OPC_MOV, OP_MOV_REG, 3'b000, req_rd, req_sh, req_rm};
            K_ADD:   enc_word = {OPC_ALU, OP_ADD, req_rn, req_rd, req_sh, req_rm};
            K_CMP:   enc_word = {OPC_ALU, OP_CMP, req_rn, 3'b000, req_sh, req_rm};
            K_AND:   enc_word = {OPC_ALU, OP_AND, req_rn, req_rd, req_sh, req_rm};
            K_MVN:   enc_word = {OPC_ALU, OP_MVN, 3'b000, req_rd, req_sh, req_rm};
            default: enc_legal = 1'b0;
        endcase
    end

    assign req_ready   = !full;
    assign accept      = req_valid && req_ready;
    assign push        = accept && enc_legal;
    assign busy        = (state == S_START) || (state == S_RUN);
    assign timeout_hit = busy && (tcnt == TLAST);
    // Head leaves the queue on completion or when it is abandoned.
    assign pop         = timeout_hit || ((state == S_RUN) && cpu_w);

    instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (enc_word),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            tcnt        <= '0;
            cpu_in      <= '0;
            cpu_load    <= 1'b0;
            cpu_s       <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_flags   <= '0;
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            cpu_load  <= 1'b0;
            res_valid <= 1'b0;
            if (accept && !enc_legal) err_illegal <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (!empty && cpu_w) begin
                        cpu_in   <= head;
                        cpu_load <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    tcnt  <= '0;
                    cpu_s <= 1'b1;
                    state <= S_START;
                end
                S_START: begin
                    if (timeout_hit) begin
                        cpu_s       <= 1'b0;
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                        if (!cpu_w) begin
                            cpu_s <= 1'b0;
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (timeout_hit) begin
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                        if (cpu_w) begin
                            res_data  <= cpu_out;
                            res_flags <= {cpu_n, cpu_v, cpu_z};
                            res_valid <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_issuer.sv
// Directed bench for instr_issuer: drives the cpu handshake by hand and checks words/results.
module tb_instr_issuer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_kind;
    logic [2:0]  req_rn;
    logic [2:0]  req_rd;
    logic [2:0]  req_rm;
    logic [1:0]  req_sh;
    logic [7:0]  req_imm8;
    logic [15:0] cpu_in;
    logic        cpu_load;
    logic        cpu_s;
    logic        cpu_w;
    logic [15:0] cpu_out;
    logic        cpu_n;
    logic        cpu_v;
    logic        cpu_z;
    logic        res_valid;
    logic [15:0] res_data;
    logic [2:0]  res_flags;
    logic        err_illegal;
    logic        err_timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_issuer #(.FIFO_DEPTH(4), .TIMEOUT(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_kind    (req_kind),
        .req_rn      (req_rn),
        .req_rd      (req_rd),
        .req_rm      (req_rm),
        .req_sh      (req_sh),
        .req_imm8    (req_imm8),
        .cpu_in      (cpu_in),
        .cpu_load    (cpu_load),
        .cpu_s       (cpu_s),
        .cpu_w       (cpu_w),
        .cpu_out     (cpu_out),
        .cpu_n       (cpu_n),
        .cpu_v       (cpu_v),
        .cpu_z       (cpu_z),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_flags   (res_flags),
        .err_illegal (err_illegal),
        .err_timeout (err_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] kind, input logic [2:0] rn, input logic [2:0] rd,
                           input logic [2:0] rm, input logic [1:0] sh, input logic [7:0] imm);
        req_kind = kind; req_rn = rn; req_rd = rd; req_rm = rm; req_sh = sh; req_imm8 = imm;
    endtask

    task automatic push(input logic [2:0] kind, input logic [2:0] rn, input logic [2:0] rd,
                        input logic [2:0] rm, input logic [1:0] sh, input logic [7:0] imm);
        int n;
        n = 0;
        set_req(kind, rn, rd, rm, sh, imm);
        req_valid = 1'b1;
        while (!req_ready && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) check("push_ready_wait", 32'd0, 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    // Walk one instruction through load/start/busy/done and check the result capture.
    task automatic issue(input logic [15:0] word, input logic [15:0] out, input logic [2:0] fl);
        int n;
        n = 0;
        cpu_w = 1'b1;
        while (!cpu_load && n < 100) begin
            step();
            n++;
        end
        check("load_seen", {31'd0, cpu_load}, 32'd1);
        check("cpu_in", {16'd0, cpu_in}, {16'd0, word});
        step();
        check("cpu_s_on", {31'd0, cpu_s}, 32'd1);
        check("load_one_cycle", {31'd0, cpu_load}, 32'd0);
        cpu_w = 1'b0;
        step();
        check("cpu_s_off", {31'd0, cpu_s}, 32'd0);
        cpu_out = out;
        {cpu_n, cpu_v, cpu_z} = fl;
        step();
        check("no_res_while_busy", {31'd0, res_valid}, 32'd0);
        cpu_w = 1'b1;
        step();
        check("res_valid", {31'd0, res_valid}, 32'd1);
        check("res_data", {16'd0, res_data}, {16'd0, out});
        check("res_flags", {29'd0, res_flags}, {29'd0, fl});
        check("cpu_in_hold", {16'd0, cpu_in}, {16'd0, word});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hits;
        reset = 1'b1;
        req_valid = 1'b0;
        set_req(3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 8'd0);
        cpu_w = 1'b1;
        cpu_out = 16'h0000;
        {cpu_n, cpu_v, cpu_z} = 3'b000;
        step();
        step();
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_cpu_in", {16'd0, cpu_in}, 32'd0);
        check("rst_ctrl", {29'd0, cpu_load, cpu_s, res_valid}, 32'd0);
        check("rst_errs", {30'd0, err_illegal, err_timeout}, 32'd0);
        check("rst_res", {13'd0, res_flags, res_data}, 32'd0);
        reset = 1'b0;
        step();

        // MOVI Rn=0 #7: load exactly one cycle after the push.
        push(3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 8'd7);
        check("movi_no_early_load", {31'd0, cpu_load}, 32'd0);
        step();
        check("movi_load_latency", {31'd0, cpu_load}, 32'd1);
        issue(16'hD007, 16'h0007, 3'b000);
        step();
        check("res_pulse_one_cycle", {31'd0, res_valid}, 32'd0);

        push(3'd2, 3'd1, 3'd2, 3'd0, 2'b01, 8'd0);
        issue(16'hA148, 16'h0009, 3'b000);
        push(3'd3, 3'd1, 3'd0, 3'd0, 2'b00, 8'd0);
        issue(16'hA900, 16'hFFFE, 3'b100);

        // MVN then MOV back to back: strict order.
        push(3'd5, 3'd0, 3'd3, 3'd1, 2'b00, 8'd0);
        push(3'd1, 3'd0, 3'd4, 3'd2, 2'b10, 8'd0);
        issue(16'hB861, 16'h1234, 3'b001);
        issue(16'hC092, 16'h5678, 3'b010);

        // Fill the queue with the cpu busy; the fifth request must stall.
        cpu_w = 1'b0;
        push(3'd0, 3'd1, 3'd0, 3'd0, 2'd0, 8'hA5);
        push(3'd4, 3'd2, 3'd3, 3'd4, 2'b11, 8'd0);
        push(3'd0, 3'd7, 3'd0, 3'd0, 2'd0, 8'hFF);
        push(3'd1, 3'd0, 3'd5, 3'd6, 2'b00, 8'd0);
        set_req(3'd2, 3'd0, 3'd0, 3'd0, 2'd0, 8'd0);
        req_valid = 1'b1;
        check("full_ready_low", {31'd0, req_ready}, 32'd0);
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (cpu_load || req_ready) hits++;
        end
        check("full_stall_no_load", hits, 32'd0);
        req_valid = 1'b0;
        issue(16'hD1A5, 16'h00A5, 3'b000);
        issue(16'hB27C, 16'h0004, 3'b001);
        issue(16'hD7FF, 16'h00FF, 3'b000);
        issue(16'hC0A6, 16'h0006, 3'b000);
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (cpu_load) hits++;
        end
        check("drained_empty", hits, 32'd0);

        // Illegal kind is accepted and dropped.
        set_req(3'd6, 3'd1, 3'd1, 3'd1, 2'd0, 8'd0);
        req_valid = 1'b1;
        check("illegal_ready", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        check("err_illegal_set", {31'd0, err_illegal}, 32'd1);
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (cpu_load) hits++;
        end
        check("illegal_no_load", hits, 32'd0);

        // cpu never leaves idle: abandoned after 64 cycles of cpu_s.
        push(3'd0, 3'd2, 3'd0, 3'd0, 2'd0, 8'h11);
        n = 0;
        while (!cpu_load && n < 100) begin
            step();
            n++;
        end
        check("to_cpu_in", {16'd0, cpu_in}, 32'h0000D211);
        check("to_err_before", {31'd0, err_timeout}, 32'd0);
        step();
        n = 0;
        hits = 0;
        while (cpu_s && n < 200) begin
            n++;
            if (res_valid) hits++;
            step();
        end
        check("to_cpu_s_cycles", n, 32'd64);
        check("to_err_timeout", {31'd0, err_timeout}, 32'd1);
        check("to_no_res", {31'd0, res_valid} + hits, 32'd0);
        push(3'd2, 3'd3, 3'd1, 3'd2, 2'b00, 8'd0);
        issue(16'hA322, 16'h0042, 3'b000);
        check("errs_sticky", {30'd0, err_illegal, err_timeout}, 32'd3);

        // Reset in the middle of RUN with a second word still queued.
        push(3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 8'h01);
        push(3'd0, 3'd3, 3'd0, 3'd0, 2'd0, 8'h33);
        n = 0;
        while (!cpu_load && n < 100) begin
            step();
            n++;
        end
        check("rr_cpu_in", {16'd0, cpu_in}, 32'h0000D001);
        step();
        cpu_w = 1'b0;
        step();
        check("rr_in_run", {31'd0, cpu_s}, 32'd0);
        reset = 1'b1;
        #1;
        check("rr_cpu_in_clr", {16'd0, cpu_in}, 32'd0);
        check("rr_ctrl_clr", {29'd0, cpu_load, cpu_s, res_valid}, 32'd0);
        check("rr_errs_clr", {30'd0, err_illegal, err_timeout}, 32'd0);
        check("rr_res_clr", {13'd0, res_flags, res_data}, 32'd0);
        check("rr_ready", {31'd0, req_ready}, 32'd1);
        cpu_w = 1'b1;
        step();
        reset = 1'b0;
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (cpu_load || res_valid) hits++;
        end
        check("rr_queue_flushed", hits, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
